free_list: RTL and testbench

- Circular FIFO of free physical register indices for the R10K-style rename path.
- Dispatch pops up to WAY new tags (T) per cycle from the head.
- Retire pushes up to WAY released tags (Told) per cycle at the tail.
- A retire-head pointer tracks the committed allocation point. On a branch-mispredict squash the speculative head rolls back to it, so all speculatively allocated tags return to the list in one cycle.

---
 rtl/free_list.sv | 72 +++++++
 tb/tb_free_list.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for rename.
// Dispatch pops from head, retire pushes at tail, squash rolls head back to retire_head.
module free_list #(
    parameter int WAY = 2,
    parameter int PHY_REG_NUM = 64,
    parameter int ARCH_REG_NUM = 32,
    localparam int PR_W = $clog2(PHY_REG_NUM),
    localparam int FL_SIZE = PHY_REG_NUM - ARCH_REG_NUM,
    localparam int IDX_W = $clog2(FL_SIZE),
    localparam int PTR_W = IDX_W + 1,
    localparam int CNT_W = $clog2(WAY + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_W-1:0]    dispatch_req_num,
    output logic [WAY*PR_W-1:0] alloc_T,
    output logic [CNT_W-1:0]    alloc_num,
    output logic [CNT_W-1:0]    avail_num,
    input  logic [WAY-1:0]      retire_free_mask,
    input  logic [WAY*PR_W-1:0] retire_Told,
    input  logic                squash,
    output logic [PTR_W-1:0]    free_count
);
    logic [PR_W-1:0]  entries_q [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, rhead_q, rhead_d;
    logic [CNT_W-1:0] n_free;
    logic [IDX_W-1:0] wr_idx [WAY];

    assign free_count = tail_q - head_q;
    assign avail_num  = (free_count >= PTR_W'(WAY)) ? CNT_W'(WAY) : CNT_W'(free_count);
    assign alloc_num  = squash ? '0 : (dispatch_req_num < avail_num ? dispatch_req_num : avail_num);

    // Frees are compacted: the k-th set mask bit lands at tail+k.
    always_comb begin
        n_free = '0;
        for (int i = 0; i < WAY; i++) begin
            wr_idx[i] = IDX_W'(tail_q + PTR_W'(n_free));
            n_free = n_free + CNT_W'(retire_free_mask[i]);
        end
    end

    always_comb begin
        alloc_T = '0;
        for (int i = 0; i < WAY; i++)
            alloc_T[i*PR_W +: PR_W] = entries_q[IDX_W'(head_q + PTR_W'(i))];
    end

    assign tail_d  = tail_q + PTR_W'(n_free);
    assign rhead_d = rhead_q + PTR_W'(n_free);
    assign head_d  = squash ? rhead_d : head_q + PTR_W'(alloc_num);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= PTR_W'(FL_SIZE);
            for (int i = 0; i < FL_SIZE; i++)
                entries_q[i] <= PR_W'(ARCH_REG_NUM + i);
        end else begin
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
            for (int i = 0; i < WAY; i++)
                if (retire_free_mask[i])
                    entries_q[wr_idx[i]] <= retire_Told[i*PR_W +: PR_W];
        end
    end

    // A free into a full list would overwrite a live tag.
    a_no_free_when_full: assert property (@(posedge clock) disable iff (reset)
        !(free_count == PTR_W'(FL_SIZE) && |retire_free_mask));
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vector table plus scoreboard round trips for free_list.
module tb_free_list;
    localparam int PR_W = 6;
    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] req = '0;
    logic [1:0]       mask = '0;
    logic [2*PR_W-1:0] told = '0;
    logic             squash = 1'b0;
    logic [2*PR_W-1:0] alloc_T;
    logic [CNT_W-1:0] alloc_num, avail_num;
    logic [5:0]       free_count;

    int checks = 0;
    int errors = 0;
    int q[$];
    int inflight[$];
    bit seen[64];
    int dups = 0;
    bit collect = 0;

    free_list dut (
        .clock(clock), .reset(reset), .dispatch_req_num(req), .alloc_T(alloc_T),
        .alloc_num(alloc_num), .avail_num(avail_num), .retire_free_mask(mask),
        .retire_Told(told), .squash(squash), .free_count(free_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int req; int mask; int told0; int told1; int sq;
        int num; int avail; int fc; int t0; int t1;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(string name, int num, int avail, int fc, int t0, int t1);
        chk({name, ".alloc_num"}, int'(alloc_num), num);
        chk({name, ".avail_num"}, int'(avail_num), avail);
        chk({name, ".free_count"}, int'(free_count), fc);
        if (t0 >= 0) chk({name, ".slot0"}, int'(alloc_T[PR_W-1:0]), t0);
        if (t1 >= 0) chk({name, ".slot1"}, int'(alloc_T[2*PR_W-1:PR_W]), t1);
    endtask

    task automatic drive(int r, int m, int t0, int t1, int s);
        @(negedge clock);
        req = CNT_W'(r);
        mask = 2'(m);
        told = {PR_W'(t1), PR_W'(t0)};
        squash = s[0];
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        req = '0; mask = '0; squash = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
    endtask

    // Queue-based model: q holds free tags in FIFO order, inflight holds allocated ones.
    task automatic step(int r, int nf_req);
        int nf, av, num;
        int t[2];
        logic [1:0] m;
        nf = nf_req > inflight.size() ? inflight.size() : nf_req;
        m = nf == 2 ? 2'b11 : nf == 1 ? ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b01) : 2'b00;
        t[0] = 0; t[1] = 0;
        for (int i = 0; i < 2; i++) if (m[i]) t[i] = inflight.pop_front();
        av = q.size() > 2 ? 2 : q.size();
        num = r < av ? r : av;
        drive(r, int'(m), t[0], t[1], 0);
        chk_out("roundtrip", num, av, q.size(), q.size() > 0 ? q[0] : -1, q.size() > 1 ? q[1] : -1);
        if (collect)
            for (int i = 0; i < num; i++) begin
                int tag;
                tag = int'(alloc_T[i*PR_W +: PR_W]);
                if (seen[tag]) dups++;
                seen[tag] = 1'b1;
            end
        for (int i = 0; i < num; i++) inflight.push_back(q.pop_front());
        for (int i = 0; i < 2; i++) if (m[i]) q.push_back(t[i]);
    endtask

    initial begin
        //          req mask t0  t1 sq  num av  fc  t0  t1
        tbl[0] = '{2,  0,   0,  0, 0,  2,  2,  32, 32, 33};
        tbl[1] = '{2,  0,   0,  0, 0,  2,  2,  30, 34, 35};
        tbl[2] = '{0,  3,   3,  4, 0,  0,  2,  28, 36, 37};
        tbl[3] = '{2,  0,   0,  0, 1,  0,  2,  30, 36, 37};
        tbl[4] = '{0,  0,   0,  0, 0,  0,  2,  32, 34, 35};
        tbl[5] = '{2,  0,   0,  0, 0,  2,  2,  32, 34, 35};
        tbl[6] = '{2,  1,   9,  0, 0,  2,  2,  30, 36, 37};
        tbl[7] = '{1,  2,   0, 11, 0,  1,  2,  29, 38, 39};
        tbl[8] = '{0,  0,   0,  0, 0,  0,  2,  29, 39, 40};

        repeat (2) @(negedge clock);
        reset = 1'b0;

        drive(0, 0, 0, 0, 0);
        chk_out("reset_idle", 0, 2, 32, 32, 33);
        for (int c = 0; c < 16; c++) begin
            drive(2, 0, 0, 0, 0);
            chk_out("drain", 2, 2, 32 - 2 * c, 32 + 2 * c, 33 + 2 * c);
        end
        drive(2, 0, 0, 0, 0);
        chk_out("empty", 0, 0, 0, -1, -1);
        drive(2, 3, 7, 5, 0);
        chk_out("free_same_cycle", 0, 0, 0, -1, -1);
        drive(0, 0, 0, 0, 0);
        chk_out("free_next_cycle", 0, 2, 2, 7, 5);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].req, tbl[i].mask, tbl[i].told0, tbl[i].told1, tbl[i].sq);
            chk_out($sformatf("tbl%0d", i), tbl[i].num, tbl[i].avail, tbl[i].fc, tbl[i].t0, tbl[i].t1);
        end

        do_reset();
        repeat (11) drive(2, 0, 0, 0, 0);
        drive(2, 1, 20, 0, 0);
        chk_out("simul", 2, 2, 10, 54, 55);
        for (int k = 0; k < 4; k++) begin
            drive(2, 0, 0, 0, 0);
            chk_out("simul_drain", 2, 2, 9 - 2 * k, 56 + 2 * k, 57 + 2 * k);
        end
        drive(2, 0, 0, 0, 0);
        chk_out("simul_last", 1, 1, 1, 20, -1);

        do_reset();
        for (int c = 0; c < 120; c++) step($urandom_range(0, 2), $urandom_range(0, 2));
        while (inflight.size() > 0) step(0, 2);
        collect = 1'b1;
        for (int c = 0; c < 17; c++) step(2, 0);
        collect = 1'b0;
        chk("unique_tags", dups, 0);
        for (int c = 0; c < 6; c++) step(2, 1);

        @(negedge clock);
        req = '0; mask = '0;
        #1 reset = 1'b1;
        #1 chk_out("async_reset", 0, 2, 32, 32, 33);
        @(negedge clock);
        reset = 1'b0;
        #1 chk_out("after_reset", 0, 2, 32, 32, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
